branch_update_unit: RTL and testbench
=====================================

# branch_update_unit

Writer side of the pipeline's branch prediction: resolves conditional branches in Execute against the prediction carried down from Decode and trains a 2-bit-counter BHT plus direct-mapped BTB. Owns the table storage and serves a combinational lookup port to Decode. Issues the redirect and flush on a mispredict. Sits between the Execute-stage ALU/branch compare and the Fetch/Decode hazard logic.

## Interface
- ENTRIES, 256: number of BHT/BTB entries; power of two.
- IDX_W, 8: log2(ENTRIES).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- BranchE  in  1  conditional branch (OP 1100011) valid in Execute.
- TakenE  in  1  resolved branch outcome.
- PredTakenE  in  1  prediction carried from Decode.
- PredTargetE  in  32  predicted target carried from Decode.
- PCE  in  32  PC of the Execute instruction.
- PCTargetE  in  32  computed branch target.
- PCPlus4E  in  32  PCE+4.
- PCD  in  32  Decode PC for lookup.
- LkTaken  out  1  predict taken for PCD.
- LkTarget  out  32  predicted target for PCD.
- Ready  out  1  table initialised.
- Redirect  out  1  mispredict in Execute.
- RedirectPC  out  32  corrected fetch PC.
- FlushD, FlushE  out  1  flush Decode and Execute.
- BrCount, MissCount  out  32  performance counters (macro-gated).

## Operation
- Index = PC[IDX_W+1:2]; entry = {cnt[1:0], valid, target[31:0]}.
- FSM INIT -> READY. In INIT, a pointer clears one entry per cycle: cnt=01 (weak not-taken), valid=0. INIT advances to READY after entry ENTRIES-1 is cleared. INIT therefore lasts ENTRIES cycles.
- Ready=1 only in READY. In INIT, LkTaken=0 and training is suppressed; Redirect is still computed.
- Lookup (combinational): LkTaken = valid & cnt[1]; LkTarget = target. A pending update to the same index is forwarded.
- Mispredict: Redirect = BranchE & ((TakenE != PredTakenE) | (TakenE & PredTakenE & PredTargetE != PCTargetE)).
- RedirectPC = TakenE ? PCTargetE : PCPlus4E. FlushD = FlushE = Redirect.
- Training: when BranchE & Ready, the update register U captures {idx, new cnt, taken, PCTargetE}. The table is written on the following edge.
- New counter uses the saturating rule: taken increments toward 11, not-taken decrements toward 00. The base value is the table entry, or U's value if U targets the same index.
- Taken writes target and sets valid. Not-taken writes only cnt.

## Timing
- Reset values: Ready=0, U invalid, FSM=INIT, pointer=0, counters=0. Redirect, FlushD, FlushE, LkTaken are all 0 while inputs are idle.
- Redirect, flushes, and lookup are combinational, with zero latency.
- Update latency: BranchE at edge N lands in U, and the table is written at edge N+1. A lookup in the cycle between sees it via the bypass.
- Back-to-back branches on the same index compound correctly: two takens from 01 give 11.
- Saturation: 11 plus taken stays 11; 00 plus not-taken stays 00.
- Reset mid-operation discards U and restarts INIT from entry 0.
- A lookup and an update to the same index in the same cycle return the updated value.

## Configuration
- BTU_PERF_CNT_EN defined: BrCount increments on every BranchE, and MissCount on every Redirect. Both are 32-bit, wrap at 2^32, and reset to 0.
- BTU_PERF_CNT_EN undefined: counters are not built and both outputs are tied to 0.

## Structure
- Package bp_pkg holds:
  - counter localparams SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the FSM state type {INIT, READY};
  - the entry struct;
  - the index function and the saturating-update function.
- One sub-module, bp_table_ram: ENTRIES x 35 storage with one async read port, one sync write port, and internal write-forwarding.

## Test plan
- Reset, then idle: Ready rises exactly 256 cycles after rst_n deasserts; LkTaken=0 for all PCD.
- PCE=0x40, taken twice, target 0x80 -> the lookup of PCD=0x40 two cycles after the second branch gives LkTaken=1, LkTarget=0x80.
- PredTakenE=0, TakenE=1, PCTargetE=0x100 -> same cycle: Redirect=FlushD=FlushE=1, RedirectPC=0x100.
- PredTakenE=1, TakenE=0, PCPlus4E=0x48 -> Redirect=1, RedirectPC=0x48. Counter 11 drops to 10, so the prediction stays taken.
- Predicted taken and correct, but PredTargetE=0x90 while PCTargetE=0xA0 -> Redirect=1, and the BTB is updated to 0xA0.
- rst_n pulsed with an update pending -> the entry is unchanged after INIT and Ready is 0 for 256 cycles. With BTU_PERF_CNT_EN defined, BrCount and MissCount count branches and mispredicts and clear on reset.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor writer side:
// 2-bit counter encodings, FSM state, table entry layout, index and counter update.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic [1:0]  cnt;
    logic        valid;
    logic [31:0] target;
  } bp_entry_t;

  // Word index of a PC, masked to idx_w bits; callers keep the low idx_w bits.
  function automatic logic [31:0] bp_word_index(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [1:0] bp_sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST) ? ST : cnt + 2'd1;
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_table_ram.sv
// BHT/BTB storage: ENTRIES x 35 bits, async read, sync write with a cnt-only mode,
// and read-side forwarding of the write being committed this cycle.
module bp_table_ram
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 256,
  parameter int unsigned IDX_W   = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wfull,
  input  logic [IDX_W-1:0] waddr,
  input  bp_entry_t        wdata,
  input  logic [IDX_W-1:0] raddr,
  output bp_entry_t        rdata
);

  bp_entry_t mem [ENTRIES];

  // wfull=0 updates only the counter, leaving valid/target untouched.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr].cnt <= wdata.cnt;
      if (wfull) begin
        mem[waddr].valid  <= wdata.valid;
        mem[waddr].target <= wdata.target;
      end
    end
  end

  always_comb begin
    rdata = mem[raddr];
    if (we && (waddr == raddr)) begin
      rdata.cnt = wdata.cnt;
      if (wfull) begin
        rdata.valid  = wdata.valid;
        rdata.target = wdata.target;
      end
    end
  end

endmodule

// File: rtl/branch_update_unit.sv
// Resolves Execute branches, issues redirect/flush, trains the BHT/BTB and serves Decode lookups.
// Optional performance counters are built when BTU_PERF_CNT_EN is defined.
module branch_update_unit
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 256,
  parameter int unsigned IDX_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        BranchE,
  input  logic        TakenE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] PCPlus4E,
  input  logic [31:0] PCD,
  output logic        LkTaken,
  output logic [31:0] LkTarget,
  output logic        Ready,
  output logic        Redirect,
  output logic [31:0] RedirectPC,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  bp_state_e        state_q;
  logic [IDX_W-1:0] ptr_q;

  logic             u_vld_q;
  logic [IDX_W-1:0] u_idx_q;
  logic [1:0]       u_cnt_q;
  logic             u_taken_q;
  logic [31:0]      u_target_q;

  logic [31:0]      ex_word, lk_word;
  logic [IDX_W-1:0] ex_idx, lk_idx;
  logic             unused_idx_hi;
  bp_entry_t        ex_rd, lk_rd;

  logic             we, wfull;
  logic [IDX_W-1:0] waddr;
  bp_entry_t        wdata;
  logic             train;

  assign ex_word       = bp_word_index(PCE, IDX_W);
  assign lk_word       = bp_word_index(PCD, IDX_W);
  assign ex_idx        = ex_word[IDX_W-1:0];
  assign lk_idx        = lk_word[IDX_W-1:0];
  assign unused_idx_hi = ^{ex_word[31:IDX_W], lk_word[31:IDX_W]};

  assign Ready = (state_q == READY);
  assign train = BranchE & Ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else if (state_q == INIT) begin
      ptr_q <= ptr_q + 1'b1;
      if (ptr_q == IDX_W'(ENTRIES - 1)) state_q <= READY;
    end
  end

  // The counter base comes from the Execute-side read, which already forwards a pending U write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_vld_q    <= 1'b0;
      u_idx_q    <= '0;
      u_cnt_q    <= WNT;
      u_taken_q  <= 1'b0;
      u_target_q <= '0;
    end else begin
      u_vld_q <= train;
      if (train) begin
        u_idx_q    <= ex_idx;
        u_cnt_q    <= bp_sat_update(ex_rd.cnt, TakenE);
        u_taken_q  <= TakenE;
        u_target_q <= PCTargetE;
      end
    end
  end

  always_comb begin
    we    = u_vld_q;
    wfull = u_taken_q;
    waddr = u_idx_q;
    wdata = '{cnt: u_cnt_q, valid: 1'b1, target: u_target_q};
    if (state_q == INIT) begin
      we    = 1'b1;
      wfull = 1'b1;
      waddr = ptr_q;
      wdata = '{cnt: WNT, valid: 1'b0, target: '0};
    end
  end

  // Two identically written copies give Decode and Execute each their own read port.
  bp_table_ram #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_ram_lk (
    .clk   (clk),
    .we    (we),
    .wfull (wfull),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (lk_idx),
    .rdata (lk_rd)
  );

  bp_table_ram #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_ram_ex (
    .clk   (clk),
    .we    (we),
    .wfull (wfull),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (ex_idx),
    .rdata (ex_rd)
  );

  assign LkTaken  = Ready & lk_rd.valid & lk_rd.cnt[1];
  assign LkTarget = lk_rd.target;

  assign Redirect   = BranchE & ((TakenE != PredTakenE) |
                                 (TakenE & PredTakenE & (PredTargetE != PCTargetE)));
  assign RedirectPC = TakenE ? PCTargetE : PCPlus4E;
  assign FlushD     = Redirect;
  assign FlushE     = Redirect;

`ifdef BTU_PERF_CNT_EN
  logic [31:0] br_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (BranchE)  br_cnt_q   <= br_cnt_q + 32'd1;
      if (Redirect) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign BrCount   = br_cnt_q;
  assign MissCount = miss_cnt_q;
`else
  assign BrCount   = '0;
  assign MissCount = '0;
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// Scoreboard bench for branch_update_unit: stimulus queues expected values, a negedge monitor compares.
module tb_branch_update_unit;

  logic        clk, rst_n;
  logic        BranchE, TakenE, PredTakenE;
  logic [31:0] PredTargetE, PCE, PCTargetE, PCPlus4E, PCD;
  logic        LkTaken, Ready, Redirect, FlushD, FlushE;
  logic [31:0] LkTarget, RedirectPC, BrCount, MissCount;

  branch_update_unit #(.ENTRIES(256), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .BranchE(BranchE), .TakenE(TakenE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .PCE(PCE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .PCD(PCD),
    .LkTaken(LkTaken), .LkTarget(LkTarget), .Ready(Ready), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .FlushD(FlushD), .FlushE(FlushE), .BrCount(BrCount),
    .MissCount(MissCount)
  );

  localparam int SEL_READY = 0, SEL_LKT = 1, SEL_LKTGT = 2, SEL_REDIR = 3, SEL_RPC = 4,
                 SEL_FD = 5, SEL_FE = 6, SEL_BRC = 7, SEL_MISS = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_br   = 0;
  int   exp_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      SEL_READY: return {31'd0, Ready};
      SEL_LKT:   return {31'd0, LkTaken};
      SEL_LKTGT: return LkTarget;
      SEL_REDIR: return {31'd0, Redirect};
      SEL_RPC:   return RedirectPC;
      SEL_FD:    return {31'd0, FlushD};
      SEL_FE:    return {31'd0, FlushE};
      SEL_BRC:   return BrCount;
      default:   return MissCount;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      act = probe(e.sel);
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic push(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic push_perf();
`ifdef BTU_PERF_CNT_EN
    push("brcount", SEL_BRC, 32'(exp_br));
    push("misscount", SEL_MISS, 32'(exp_miss));
`else
    push("brcount", SEL_BRC, 32'd0);
    push("misscount", SEL_MISS, 32'd0);
`endif
  endtask

  // lk_exp: -1 skip, else expected LkTaken; chk_tgt also checks LkTarget.
  task automatic step(input logic be, input logic [31:0] pce, input logic taken, input logic pred,
                      input logic [31:0] ptgt, input logic [31:0] tgt, input logic [31:0] pcd,
                      input int lk_exp, input logic chk_tgt, input logic [31:0] lk_tgt,
                      input logic exp_redir, input logic [31:0] exp_rpc);
    @(posedge clk); #1;
    BranchE     = be;
    PCE         = pce;
    PCPlus4E    = pce + 32'd4;
    TakenE      = taken;
    PredTakenE  = pred;
    PredTargetE = ptgt;
    PCTargetE   = tgt;
    PCD         = pcd;
    push("redirect", SEL_REDIR, {31'd0, exp_redir});
    push("flushd", SEL_FD, {31'd0, exp_redir});
    push("flushe", SEL_FE, {31'd0, exp_redir});
    if (exp_redir) push("redirect_pc", SEL_RPC, exp_rpc);
    if (lk_exp >= 0) push("lk_taken", SEL_LKT, (lk_exp != 0) ? 32'd1 : 32'd0);
    if (chk_tgt) push("lk_target", SEL_LKTGT, lk_tgt);
    if (be) exp_br++;
    if (exp_redir) exp_miss++;
  endtask

  task automatic br(input logic [31:0] pce, input logic taken, input logic pred,
                    input logic [31:0] ptgt, input logic [31:0] tgt,
                    input logic exp_redir, input logic [31:0] exp_rpc);
    step(1'b1, pce, taken, pred, ptgt, tgt, 32'h0, -1, 1'b0, 32'h0, exp_redir, exp_rpc);
  endtask

  task automatic look(input logic [31:0] pcd, input int lk_exp, input logic chk_tgt,
                      input logic [31:0] lk_tgt);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, pcd, lk_exp, chk_tgt, lk_tgt, 1'b0, 32'h0);
    push_perf();
  endtask

  task automatic init_phase();
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk); #1;
      PCD = 32'(k) << 2;
      push("init_lk_taken", SEL_LKT, 32'd0);
      if (k == 1 || k >= 255) push("ready_rise", SEL_READY, (k == 256) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; BranchE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
    PredTargetE = '0; PCE = '0; PCTargetE = '0; PCPlus4E = 32'd4; PCD = '0;

    @(posedge clk); #1;
    push("reset_ready", SEL_READY, 32'd0);
    push("reset_redirect", SEL_REDIR, 32'd0);
    push("reset_lk_taken", SEL_LKT, 32'd0);
    push_perf();
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_phase();

    // Two takens from weak-not-taken, lookup through the U bypass and then the table.
    step(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h80, 32'h40, 0, 1'b0, 32'h0, 1'b1, 32'h80);
    step(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 32'h80, 32'h40, 1, 1'b1, 32'h80, 1'b0, 32'h0);
    look(32'h40, 1, 1'b1, 32'h80);
    look(32'h40, 1, 1'b1, 32'h80);
    look(32'h440, 1, 1'b1, 32'h80);
    look(32'h48, 0, 1'b0, 32'h0);

    // Saturate at 11, then one not-taken leaves 10 and target untouched.
    br(32'h40, 1'b1, 1'b1, 32'h80, 32'h80, 1'b0, 32'h0);
    br(32'h40, 1'b0, 1'b1, 32'h80, 32'h84, 1'b1, 32'h44);
    look(32'h0, -1, 1'b0, 32'h0);
    look(32'h40, 1, 1'b1, 32'h80);

    // Mispredicted not-taken on a strongly-taken entry.
    br(32'h44, 1'b1, 1'b0, 32'h0, 32'h60, 1'b1, 32'h60);
    br(32'h44, 1'b1, 1'b1, 32'h60, 32'h60, 1'b0, 32'h0);
    br(32'h44, 1'b0, 1'b1, 32'h60, 32'h64, 1'b1, 32'h48);
    look(32'h0, -1, 1'b0, 32'h0);
    look(32'h44, 1, 1'b1, 32'h60);

    // Saturate at 00, then one taken only reaches 01.
    br(32'h300, 1'b0, 1'b0, 32'h0, 32'h310, 1'b0, 32'h0);
    br(32'h300, 1'b0, 1'b0, 32'h0, 32'h310, 1'b0, 32'h0);
    br(32'h300, 1'b1, 1'b0, 32'h0, 32'h310, 1'b1, 32'h310);
    look(32'h0, -1, 1'b0, 32'h0);
    look(32'h300, 0, 1'b1, 32'h310);

    // Correct direction, wrong target.
    br(32'h500, 1'b1, 1'b0, 32'h0, 32'h90, 1'b1, 32'h90);
    look(32'h0, -1, 1'b0, 32'h0);
    look(32'h500, 1, 1'b1, 32'h90);
    br(32'h500, 1'b1, 1'b1, 32'h90, 32'hA0, 1'b1, 32'hA0);
    look(32'h0, -1, 1'b0, 32'h0);
    look(32'h500, 1, 1'b1, 32'hA0);

    br(32'h200, 1'b1, 1'b0, 32'h0, 32'h100, 1'b1, 32'h100);
    step(1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 32'h999, 32'h0, -1, 1'b0, 32'h0, 1'b0, 32'h0);
    look(32'h0, -1, 1'b0, 32'h0);

    // Reset with an update pending in U.
    br(32'h80, 1'b1, 1'b0, 32'h0, 32'h123, 1'b1, 32'h123);
    @(posedge clk); #1;
    rst_n = 1'b0;
    BranchE = 1'b0;
    exp_br = 0;
    exp_miss = 0;
    push("rst_ready", SEL_READY, 32'd0);
    push_perf();
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_phase();
    look(32'h80, 0, 1'b0, 32'h0);
    look(32'h40, 0, 1'b0, 32'h0);
    br(32'h40, 1'b1, 1'b0, 32'h0, 32'h80, 1'b1, 32'h80);
    look(32'h0, -1, 1'b0, 32'h0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
